fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Instruction fetch plus decode front end for the multicycle RV32I subset datapath (lw, sw, sub, xor, addi, srl, beq).
- Holds a small word-addressed instruction memory, registers the instruction at the PC supplied by the PC adder, then registers the split fields, immediate and format class.
- Feeds the control-signal and register-file blocks.
- The clock is an input from the system clock source; this block generates no clock.

Parameters:
- DEPTH, 8, number of 32-bit instruction words in memory; PC valid range 0..DEPTH-1.
- PC_W, 32, width of the PC input, a word index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  PC_W  word index of the instruction to fetch.
- in_valid  in  1  fetch request this cycle.
- imem_we  in  1  instruction memory load strobe.
- imem_waddr  in  $clog2(DEPTH)  load address.
- imem_wdata  in  32  load data.
- instrucao  out  32  registered fetched instruction.
- opcode  out  7  decoded instr[6:0].
- rd  out  5  decoded instr[11:7].
- rs1  out  5  decoded instr[19:15].
- rs2  out  5  decoded instr[24:20].
- funct3  out  3  decoded instr[14:12].
- funct7  out  7  decoded instr[31:25].
- immediate  out  12  format-dependent immediate.
- tipo  out  3  format class.
- out_valid  out  1  decoded outputs valid.

Behaviour:
- Memory:
  - DEPTH x 32 array. Reset does not clear it.
  - A write with imem_we=1 takes effect at the clock edge and is readable by a fetch on the next cycle.
  - Same-cycle write and fetch at one address: fetch returns the old data.
- Stage 1 (fetch register), when in_valid=1:
  - instrucao <= mem[pc] if pc < DEPTH, else 32'h0.
  - v1 <= in_valid.
- Stage 2 (decode register):
  - opcode, rd, rs1, rs2, funct3 and funct7 come from the stage-1 instrucao.
  - Decode registers update every cycle. out_valid <= v1.
- Latency: pc/in_valid in cycle N gives instrucao at edge N+1 and decoded fields plus out_valid at edge N+2. Fully pipelined, one fetch per cycle, no stall.
- tipo encoding (constants), by opcode:
  - 0 NONE: any other opcode.
  - 1 R: 0110011.
  - 2 I: 0010011.
  - 3 LOAD: 0000011.
  - 4 S: 0100011.
  - 5 B: 1100011.
- immediate by tipo:
  - I and LOAD: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8]}, which is byte offset bits 12:1.
  - R and NONE: 0.
- Raw fields are always output regardless of tipo.
- Reset, synchronous and checked at the clock edge:
  - instrucao, all decoded fields and immediate go to 0.
  - tipo goes to NONE. out_valid goes to 0.
  - Reset overrides in_valid in the same cycle.
  - Reset mid-stream drops in-flight fetches; no stale out_valid after reset is released.
- Out-of-range pc: instrucao=0, decodes as tipo NONE with out_valid=1.

Decomposition:
- Shared package (also used by sinaisdecontrole):
  - tipo constants TIPO_NONE/R/I/LOAD/S/B.
  - opcode constants OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_S=0100011, OP_B=1100011.
  - funct3/funct7 constants for sub, xor, srl, lw, sw, beq.
- One sub-module is natural: instr_decoder, the combinational field split, immediate and tipo logic, registered by the parent.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 -> all outputs 0, tipo=0, out_valid=0.
- Load mem[0]=0x00500093 and fetch pc=0 -> after 2 edges: opcode=0010011, rd=1, rs1=0, funct3=0, immediate=0x005, tipo=2, out_valid=1; instrucao=0x00500093 after 1 edge.
- mem[1]=0x402081B3 (sub x3,x1,x2) -> rd=3, rs1=1, rs2=2, funct7=0100000, tipo=1, immediate=0.
  - mem[2]=0x0080A203 (lw x4,8(x1)) -> funct3=010, immediate=0x008, tipo=3.
- mem[3]=0x0040A623 (sw x4,12(x1)) -> rs1=1, rs2=4, immediate=0x00C, tipo=4.
  - mem[4]=0xFE208CE3 (beq x1,x2,-8) -> rs1=1, rs2=2, immediate=0xFFC, tipo=5.
- Back-to-back pc=0..4, one per cycle -> five consecutive out_valid cycles in order with the values above. Then:
  - pc=9 -> instrucao=0, tipo=0.
  - mem[5]=0x0000007F -> tipo=0.
- Assert reset while the pipeline is full -> outputs cleared on the next edge, out_valid stays 0 until a new fetch.

Source files
------------

// File: rtl/fetch_decode_unit_pkg.sv
// rtl/fetch_decode_unit_pkg.sv - opcode, funct and format-class constants shared by the front end and control
package fetch_decode_unit_pkg;

  typedef enum logic [2:0] {
    TIPO_NONE = 3'd0,
    TIPO_R    = 3'd1,
    TIPO_I    = 3'd2,
    TIPO_LOAD = 3'd3,
    TIPO_S    = 3'd4,
    TIPO_B    = 3'd5
  } tipo_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_XOR = 7'b0000000;
  localparam logic [6:0] F7_SRL = 7'b0000000;

  function automatic tipo_t tipo_of(input logic [6:0] op);
    case (op)
      OP_R:    return TIPO_R;
      OP_I:    return TIPO_I;
      OP_LOAD: return TIPO_LOAD;
      OP_S:    return TIPO_S;
      OP_B:    return TIPO_B;
      default: return TIPO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// rtl/fetch_decode_unit_if.sv - fetch request, imem load port and decoded instruction bundle
interface fetch_decode_unit_if
  import fetch_decode_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
);
  logic [PC_W-1:0]          pc;
  logic                     in_valid;
  logic                     imem_we;
  logic [$clog2(DEPTH)-1:0] imem_waddr;
  logic [31:0]              imem_wdata;

  logic [31:0] instrucao;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] immediate;
  tipo_t       tipo;
  logic        out_valid;

  modport master (
    output pc, in_valid, imem_we, imem_waddr, imem_wdata,
    input  instrucao, opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo, out_valid
  );

  modport slave (
    input  pc, in_valid, imem_we, imem_waddr, imem_wdata,
    output instrucao, opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo, out_valid
  );
endinterface

// File: rtl/fetch_decode_unit_instr_decoder.sv
// rtl/fetch_decode_unit_instr_decoder.sv - combinational field split, format class and immediate
module instr_decoder
  import fetch_decode_unit_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] immediate,
  output tipo_t       tipo
);
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign tipo   = tipo_of(instr[6:0]);

  // Branch immediate is the byte offset with its always-zero bit 0 dropped
  always_comb begin
    immediate = '0;
    case (tipo)
      TIPO_I, TIPO_LOAD: immediate = instr[31:20];
      TIPO_S:            immediate = {instr[31:25], instr[11:7]};
      TIPO_B:            immediate = {instr[31], instr[7], instr[30:25], instr[11:8]};
      default:           immediate = '0;
    endcase
  end
endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - two-stage instruction fetch and decode front end
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
)
(
  input logic               clk,
  input logic               reset,
  fetch_decode_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [31:0] instr_q;
  logic        v1;

  logic [6:0]  opcode_d, funct7_d;
  logic [4:0]  rd_d, rs1_d, rs2_d;
  logic [2:0]  funct3_d;
  logic [11:0] imm_d;
  tipo_t       tipo_d;

  logic [6:0]  opcode_q, funct7_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic [11:0] imm_q;
  tipo_t       tipo_q;
  logic        valid_q;

  // Program memory survives reset; a same-edge fetch sees the pre-write word
  always_ff @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      v1      <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid)
        instr_q <= (bus.pc < PC_W'(DEPTH)) ? mem[bus.pc[AW-1:0]] : 32'h0;
    end
  end

  instr_decoder u_dec (
    .instr     (instr_q),
    .opcode    (opcode_d),
    .rd        (rd_d),
    .rs1       (rs1_d),
    .rs2       (rs2_d),
    .funct3    (funct3_d),
    .funct7    (funct7_d),
    .immediate (imm_d),
    .tipo      (tipo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q    <= '0;
      tipo_q   <= TIPO_NONE;
      valid_q  <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      imm_q    <= imm_d;
      tipo_q   <= tipo_d;
      valid_q  <= v1;
    end
  end

  assign bus.instrucao = instr_q;
  assign bus.opcode    = opcode_q;
  assign bus.rd        = rd_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.funct3    = funct3_q;
  assign bus.funct7    = funct7_q;
  assign bus.immediate = imm_q;
  assign bus.tipo      = tipo_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - randomized and directed bench for fetch_decode_unit
module tb_fetch_decode_unit;
  import fetch_decode_unit_pkg::*;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic [2:0]  tipo;
  } dec_t;

  typedef struct {
    bit          v;
    logic [31:0] w;
  } pend_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mm [DEPTH];
  logic [31:0] prog [6] = '{32'h00500093, 32'h402081B3, 32'h0080A203,
                            32'h0040A623, 32'hFE208CE3, 32'h0000007F};
  dec_t want [7];

  fetch_decode_unit_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  fetch_decode_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference decode from the ISA field positions, using integer arithmetic
  function automatic dec_t model(input logic [31:0] w);
    dec_t        d;
    int unsigned u;
    int unsigned off;
    u        = w;
    d.opcode = 7'(u % 128);
    d.rd     = 5'((u >> 7) % 32);
    d.funct3 = 3'((u >> 12) % 8);
    d.rs1    = 5'((u >> 15) % 32);
    d.rs2    = 5'((u >> 20) % 32);
    d.funct7 = 7'(u >> 25);
    case (d.opcode)
      7'b0110011: d.tipo = 3'd1;
      7'b0010011: d.tipo = 3'd2;
      7'b0000011: d.tipo = 3'd3;
      7'b0100011: d.tipo = 3'd4;
      7'b1100011: d.tipo = 3'd5;
      default:    d.tipo = 3'd0;
    endcase
    case (d.tipo)
      3'd2, 3'd3: d.imm = 12'(u >> 20);
      3'd4:       d.imm = 12'(int'(d.funct7) * 32 + int'(d.rd));
      3'd5: begin
        off   = (u >> 31) * 4096 + ((u >> 7) % 2) * 2048 + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
        d.imm = 12'(off / 2);
      end
      default:    d.imm = 12'd0;
    endcase
    return d;
  endfunction

  function automatic dec_t observed();
    dec_t d;
    d.opcode = bus.opcode;
    d.rd     = bus.rd;
    d.rs1    = bus.rs1;
    d.rs2    = bus.rs2;
    d.funct3 = bus.funct3;
    d.funct7 = bus.funct7;
    d.imm    = bus.immediate;
    d.tipo   = bus.tipo;
    return d;
  endfunction

  function automatic logic [31:0] fetch_word(input int pc);
    return (pc < DEPTH) ? mm[pc] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 3'(a);
    bus.imem_wdata = d;
    step();
    bus.imem_we = 1'b0;
    mm[a]       = d;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.pc       = '0;
    bus.imem_we  = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    step();
    step();
    checks++; if (bus.instrucao !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instrucao); end
    checks++; if (observed() !== dec_t'(0)) begin errors++; $display("FAIL reset_fields: got %h expected 0", observed()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.tipo !== TIPO_NONE) begin errors++; $display("FAIL release_tipo: got %0d expected 0", bus.tipo); end
  endtask

  task automatic test_single_fetch();
    for (int i = 0; i < 6; i++) load(i, prog[i]);
    load(6, $urandom());
    load(7, $urandom());
    for (int i = 0; i < 5; i++) begin
      bus.pc       = PC_W'(i);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.instrucao !== prog[i]) begin errors++; $display("FAIL single_instr pc=%0d: got %h expected %h", i, bus.instrucao, prog[i]); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid pc=%0d: got %b expected 0", i, bus.out_valid); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid pc=%0d: got %b expected 1", i, bus.out_valid); end
      checks++; if (observed() !== want[i]) begin errors++; $display("FAIL single_fields pc=%0d: got %h expected %h", i, observed(), want[i]); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drop pc=%0d: got %b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int pcs [7] = '{0, 1, 2, 3, 4, 9, 5};
    int idx [7] = '{0, 1, 2, 3, 4, 6, 5};
    logic [31:0] w;
    for (int c = 0; c < 10; c++) begin
      if (c < 7) begin
        bus.pc       = PC_W'(pcs[c]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (c < 7) begin
        w = (pcs[c] < DEPTH) ? prog[pcs[c]] : 32'h0;
        checks++; if (bus.instrucao !== w) begin errors++; $display("FAIL b2b_instr c=%0d: got %h expected %h", c, bus.instrucao, w); end
      end
      if (c >= 1 && c <= 7) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d: got %b expected 1", c, bus.out_valid); end
        checks++; if (observed() !== want[idx[c-1]]) begin errors++; $display("FAIL b2b_fields c=%0d: got %h expected %h", c, observed(), want[idx[c-1]]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d: got %b expected 0", c, bus.out_valid); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      bus.pc       = PC_W'(i);
      bus.in_valid = 1'b1;
      step();
    end
    reset  = 1'b1;
    bus.pc = PC_W'(3);
    step();
    checks++; if (bus.instrucao !== 32'h0) begin errors++; $display("FAIL mid_instr: got %h expected 0", bus.instrucao); end
    checks++; if (observed() !== dec_t'(0)) begin errors++; $display("FAIL mid_fields: got %h expected 0", observed()); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c=%0d: got %b expected 0", i, bus.out_valid); end
    end
    bus.pc       = PC_W'(1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_refetch_valid: got %b expected 1", bus.out_valid); end
    checks++; if (observed() !== want[1]) begin errors++; $display("FAIL mid_refetch_fields: got %h expected %h", observed(), want[1]); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1010101};
    pend_t       q [$];
    pend_t       e;
    int          pc;
    int          wa;
    bit          v;
    bit          we;
    logic [31:0] wd;
    q.push_back('{1'b0, 32'h0});
    for (int c = 0; c < 300; c++) begin
      pc = $urandom_range(0, 11);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      wa = (c % 5 == 0) ? pc % DEPTH : $urandom_range(0, DEPTH - 1);
      wd = $urandom();
      wd[6:0] = ops[$urandom_range(0, 5)];
      q.push_back('{v, v ? fetch_word(pc) : 32'h0});
      bus.pc         = PC_W'(pc);
      bus.in_valid   = v;
      bus.imem_we    = we;
      bus.imem_waddr = 3'(wa);
      bus.imem_wdata = wd;
      if (we) mm[wa] = wd;
      step();
      e = q[$];
      if (e.v) begin
        checks++; if (bus.instrucao !== e.w) begin errors++; $display("FAIL rand_instr c=%0d: got %h expected %h", c, bus.instrucao, e.w); end
      end
      e = q.pop_front();
      checks++; if (bus.out_valid !== e.v) begin errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, bus.out_valid, e.v); end
      if (e.v) begin
        checks++; if (observed() !== model(e.w)) begin errors++; $display("FAIL rand_fields c=%0d: got %h expected %h", c, observed(), model(e.w)); end
      end
    end
    bus.in_valid = 1'b0;
    bus.imem_we  = 1'b0;
  endtask

  initial begin
    want[0] = '{7'b0010011, 5'd1, 5'd0, 5'd5, 3'd0, 7'b0000000, 12'h005, 3'd2};
    want[1] = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 12'h000, 3'd1};
    want[2] = '{7'b0000011, 5'd4, 5'd1, 5'd8, 3'b010, 7'b0000000, 12'h008, 3'd3};
    want[3] = '{7'b0100011, 5'd12, 5'd1, 5'd4, 3'b010, 7'b0000000, 12'h00C, 3'd4};
    want[4] = '{7'b1100011, 5'd25, 5'd1, 5'd2, 3'd0, 7'b1111111, 12'hFFC, 3'd5};
    want[5] = '{7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'b0000000, 12'h000, 3'd0};
    want[6] = dec_t'(0);
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
